muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit. It sits directly downstream of the register file and consumes the two registered read-port words (rs1/rs2 data) alongside the decoded funct3. It computes all eight M-extension operations over a shared 64-bit shift datapath in 32 iterations, then presents a registered 32-bit result with a one-cycle done pulse for the writeback mux.

## Interface
- Parameters: none; the datapath is fixed at 32 bits to match the register file word width.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only while idle
- funct3  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data  in  32  operand A (dividend / multiplicand), from regfile read port 1
- rs2_data  in  32  operand B (divisor / multiplier), from regfile read port 2
- busy  out  1  high whenever state is not IDLE
- done  out  1  registered one-cycle pulse; result is valid from this cycle on
- result  out  32  registered result; holds until the next done

## Operation
- States are IDLE, CALC and SIGN.
- **IDLE**, start=1:
  - Capture funct3 and the operands as magnitudes:
    - Signed operands (MULH/DIV/REM: A and B; MULHSU: A only) with bit31 set are two's-complement negated.
  - Latch the sign flag:
    - neg = sA^sB for MULH, DIV and MUL;
    - neg = sA for MULHSU and REM;
    - neg = 0 for unsigned ops.
  - Clear the iteration counter to 0 and go to CALC.
- **IDLE**, special cases (no CALC), go straight to SIGN with a preset result:
  - Divide by zero (B=0, funct3 4-7): quotient 0xFFFFFFFF; remainder = original rs1_data.
  - Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000; remainder 0.
- **CALC**, multiply: unsigned shift-add.
  - 64-bit accumulator {hi,lo}; lo starts as the multiplier.
  - Each cycle: if lo[0], hi += multiplicand (33-bit add, keep carry); then shift {carry,hi,lo} right by 1.
- **CALC**, divide: restoring.
  - Remainder register R (33-bit), quotient register Q starts as the dividend.
  - Each cycle: {R,Q} <<= 1; if R >= divisor, R -= divisor and Q[0] = 1.
- **CALC** exit: the counter increments each cycle; after the 32nd iteration (counter = 31) go to SIGN.
- **SIGN**:
  - If neg, two's-complement the 64-bit product, the quotient, or the remainder as applicable.
  - Select the output word:
    - MUL: low word.
    - MULH/MULHSU/MULHU: high word.
    - DIV/DIVU: Q.
    - REM/REMU: R[31:0].
  - Register the selection into result, set done=1, return to IDLE.
- start while busy is ignored. The operands are captured at start; later changes on rs*_data have no effect.

## Timing
- Start sampled at edge E0; CALC iterations occur on edges E1..E32; result and done are registered at E33.
- Latency is 33 cycles for normal ops and 1 cycle for the special cases.
- busy is high from E0+ until E33.
- done is high for exactly one cycle after E33.
- A new start may be sampled in the same cycle done is high, since state is already IDLE. Throughput is one op per 33 cycles.
- Reset values: state IDLE, busy 0, done 0, result 0x00000000, counter 0.
- rst mid-operation aborts the operation. There is no done for the aborted op, and result is cleared.
- rst has priority over start in the same cycle.

## Structure
- Shared package muldiv_pkg:
  - funct3 op constants (OP_MUL..OP_REMU);
  - the state encoding (IDLE/CALC/SIGN);
  - the ITERS=32 constant.
- The CPU decoder reuses the funct3 constants to steer M-extension instructions.
- No sub-module:
  - one FSM plus a shared 64-bit accumulator;
  - a 33-bit adder/subtractor multiplexed between the multiply and divide modes.

## Test plan
- MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 cycles after start; busy high for 33 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF and REM 100/0 -> 100, each with done one cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, also 1-cycle latency.
- Back-to-back: second start asserted in the done cycle is accepted. start pulses during busy are ignored (result unchanged, a single done). rs1/rs2 toggled after start do not alter the result.
- rst asserted at cycle 10 of a DIV -> busy 0 and result 0 on the next edge with no done pulse; a fresh MUL 3*4 afterwards returns 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared op codes, FSM encoding and iteration count for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam int ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : Request/result bundle between regfile read ports and muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, rs1_data, rs2_data,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide over a shared 64-bit shift path.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [2:0]  op_q,    op_d;
    logic        neg_q,   neg_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic [31:0] b_q,     b_d;
    logic [31:0] result_q, result_d;
    logic        done_q,  done_d;

    logic        w_a_signed, w_b_signed, w_s_a, w_s_b, w_neg_in;
    logic [31:0] w_a_mag, w_b_mag;
    logic        w_alu_sub;
    logic [32:0] w_alu_x, w_alu_y;
    logic [33:0] w_alu_sum;
    logic [63:0] w_prod, w_prod_s;
    logic [31:0] w_quo_s, w_rem_s;

    // MUL is treated as fully signed: the low word is identical either way.
    always_comb begin
        w_a_signed = (bus.funct3 == OP_MUL) || (bus.funct3 == OP_MULH) ||
                     (bus.funct3 == OP_MULHSU) || (bus.funct3 == OP_DIV) ||
                     (bus.funct3 == OP_REM);
        w_b_signed = (bus.funct3 == OP_MUL) || (bus.funct3 == OP_MULH) ||
                     (bus.funct3 == OP_DIV) || (bus.funct3 == OP_REM);
        w_s_a   = w_a_signed & bus.rs1_data[31];
        w_s_b   = w_b_signed & bus.rs2_data[31];
        w_a_mag = w_s_a ? (~bus.rs1_data + 32'd1) : bus.rs1_data;
        w_b_mag = w_s_b ? (~bus.rs2_data + 32'd1) : bus.rs2_data;
        case (bus.funct3)
            OP_MUL, OP_MULH, OP_DIV: w_neg_in = w_s_a ^ w_s_b;
            OP_MULHSU, OP_REM:       w_neg_in = w_s_a;
            default:                 w_neg_in = 1'b0;
        endcase
    end

    // Shared 33-bit adder: hi + multiplicand, or shifted remainder - divisor.
    always_comb begin
        w_alu_sub = op_q[2];
        if (w_alu_sub) begin
            w_alu_x = {hi_q, lo_q[31]};
            w_alu_y = ~{1'b0, b_q};
        end else begin
            w_alu_x = {1'b0, hi_q};
            w_alu_y = lo_q[0] ? {1'b0, b_q} : 33'd0;
        end
        w_alu_sum = {1'b0, w_alu_x} + {1'b0, w_alu_y} + {33'd0, w_alu_sub};
    end

    always_comb begin
        w_prod   = {hi_q, lo_q};
        w_prod_s = neg_q ? (~w_prod + 64'd1) : w_prod;
        w_quo_s  = neg_q ? (~lo_q + 32'd1) : lo_q;
        w_rem_s  = neg_q ? (~hi_q + 32'd1) : hi_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.funct3;
                    cnt_d = 5'd0;
                    if (bus.funct3[2] && (bus.rs2_data == 32'd0)) begin
                        hi_d    = bus.rs1_data;
                        lo_d    = 32'hFFFF_FFFF;
                        neg_d   = 1'b0;
                        state_d = ST_SIGN;
                    end else if (((bus.funct3 == OP_DIV) || (bus.funct3 == OP_REM)) &&
                                 (bus.rs1_data == 32'h8000_0000) &&
                                 (bus.rs2_data == 32'hFFFF_FFFF)) begin
                        hi_d    = 32'd0;
                        lo_d    = 32'h8000_0000;
                        neg_d   = 1'b0;
                        state_d = ST_SIGN;
                    end else begin
                        neg_d   = w_neg_in;
                        hi_d    = 32'd0;
                        if (bus.funct3[2]) begin
                            lo_d = w_a_mag;
                            b_d  = w_b_mag;
                        end else begin
                            lo_d = w_b_mag;
                            b_d  = w_a_mag;
                        end
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                if (op_q[2]) begin
                    // Carry out of the subtract means shifted R >= divisor.
                    if (w_alu_sum[33]) begin
                        hi_d = w_alu_sum[31:0];
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = w_alu_x[31:0];
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end else begin
                    hi_d = w_alu_sum[32:1];
                    lo_d = {w_alu_sum[0], lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITERS - 1)) begin
                    state_d = ST_SIGN;
                end
            end

            ST_SIGN: begin
                case (op_q)
                    OP_MUL:                     result_d = w_prod_s[31:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = w_prod_s[63:32];
                    OP_DIV, OP_DIVU:            result_d = w_quo_s;
                    default:                    result_d = w_rem_s;
                endcase
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench for muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ub_s;
        logic [63:0] ua, ub, p;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        ub_s = ub;
        case (f)
            OP_MUL:    begin p = sa * sb;   return p[31:0];  end
            OP_MULH:   begin p = sa * sb;   return p[63:32]; end
            OP_MULHSU: begin p = sa * ub_s; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub;   return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Operands are scrambled right after the start cycle to prove they were captured.
    task automatic issue(input bit now, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        if (!now) @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = f;
        bus.rs1_data = a;
        bus.rs2_data = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.funct3   = 3'($urandom_range(0, 7));
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
        end while (!bus.done && lat < 100);
        check("done_seen", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic do_op(input string tag, input bit now, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
        int lat, bcnt;
        issue(now, f, a, b);
        wait_done(lat, bcnt);
        check({tag, "_res"}, bus.result, exp);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bcnt), 32'(exp_lat));
    endtask

    initial begin
        int lat, bcnt, dcnt;
        logic [2:0]  f;
        logic [31:0] a, b;
        bit special;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.funct3   = 3'd0;
        bus.rs1_data = 32'd0;
        bus.rs2_data = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, bus.busy}, 32'd0);
        check("rst_done",   {31'd0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        rst = 1'b0;

        do_op("mul",     0, OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("mulh",    0, OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        do_op("mulhu",   0, OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("mulhsu",  0, OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("div",     0, OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        do_op("rem",     0, OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        do_op("divu",    0, OP_DIVU,   32'd100,        32'd7,         32'd14,        33);
        do_op("remu",    0, OP_REMU,   32'd100,        32'd7,         32'd2,         33);
        do_op("divu_z",  0, OP_DIVU,   32'd100,        32'd0,         32'hFFFF_FFFF, 1);
        do_op("rem_z",   0, OP_REM,    32'd100,        32'd0,         32'd100,       1);
        do_op("div_ovf", 0, OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf", 0, OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Back-to-back: second start issued in the done cycle of the first.
        do_op("b2b_a", 0, OP_DIVU, 32'd1000, 32'd9, 32'd111, 33);
        do_op("b2b_b", 1, OP_MUL,  32'd6,    32'd7, 32'd42,  33);

        // Start pulses while busy must be ignored.
        issue(0, OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
            bus.start    = (i % 3 == 0);
            bus.funct3   = 3'($urandom_range(0, 7));
            bus.rs1_data = $urandom;
            bus.rs2_data = $urandom;
        end
        bus.start = 1'b0;
        check("ign_nodone", 32'(dcnt), 32'd0);
        wait_done(lat, bcnt);
        check("ign_res", bus.result, ref_model(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678));
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("ign_single", 32'(dcnt), 32'd0);

        // Randomized ops with a bias toward the divide special cases.
        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            special = f[2] && ((b == 32'd0) ||
                      ((f == OP_DIV || f == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            issue(0, f, a, b);
            wait_done(lat, bcnt);
            check("rand_res", bus.result, ref_model(f, a, b));
            check("rand_lat", 32'(lat), special ? 32'd1 : 32'd33);
        end

        // Reset in the middle of a divide.
        do_op("pre_rst", 0, OP_DIVU, 32'd77, 32'd5, 32'd15, 33);
        issue(0, OP_DIV, 32'h1234_5678, 32'd3);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",   {31'd0, bus.busy}, 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        check("mid_rst_done",   {31'd0, bus.done}, 32'd0);
        rst  = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("mid_rst_nodone", 32'(dcnt), 32'd0);
        do_op("post_rst", 0, OP_MUL, 32'd3, 32'd4, 32'd12, 33);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
